// File: rtl/unit_morse_keyer.sv
// Morse keyer: buffers ASCII characters in a small FIFO and keys them out
// as International Morse with unit-accurate mark, element, character and
// word spacing.
module unit_morse_keyer #(
    parameter int UNIT_CYCLES    = 1000,
    parameter int FIFO_DEPTH     = 4,
    parameter int WORD_GAP_UNITS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       key_out,
    output logic       busy,
    output logic       err_flag
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int UW = $clog2(WORD_GAP_UNITS) + 1;

    typedef enum logic [2:0] {IDLE, MARK, EGAP, CGAP, WGAP} state_t;

    // Returns {length, elements}; elements are right-aligned, 1 = dash.
    // A length of zero marks an unsupported code.
    function automatic logic [11:0] morse_lookup(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
        case (u)
            8'h41: return {4'd2, 8'b01};      8'h42: return {4'd4, 8'b1000};
            8'h43: return {4'd4, 8'b1010};    8'h44: return {4'd3, 8'b100};
            8'h45: return {4'd1, 8'b0};       8'h46: return {4'd4, 8'b0010};
            8'h47: return {4'd3, 8'b110};     8'h48: return {4'd4, 8'b0000};
            8'h49: return {4'd2, 8'b00};      8'h4A: return {4'd4, 8'b0111};
            8'h4B: return {4'd3, 8'b101};     8'h4C: return {4'd4, 8'b0100};
            8'h4D: return {4'd2, 8'b11};      8'h4E: return {4'd2, 8'b10};
            8'h4F: return {4'd3, 8'b111};     8'h50: return {4'd4, 8'b0110};
            8'h51: return {4'd4, 8'b1101};    8'h52: return {4'd3, 8'b010};
            8'h53: return {4'd3, 8'b000};     8'h54: return {4'd1, 8'b1};
            8'h55: return {4'd3, 8'b001};     8'h56: return {4'd4, 8'b0001};
            8'h57: return {4'd3, 8'b011};     8'h58: return {4'd4, 8'b1001};
            8'h59: return {4'd4, 8'b1011};    8'h5A: return {4'd4, 8'b1100};
            8'h30: return {4'd5, 8'b11111};   8'h31: return {4'd5, 8'b01111};
            8'h32: return {4'd5, 8'b00111};   8'h33: return {4'd5, 8'b00011};
            8'h34: return {4'd5, 8'b00001};   8'h35: return {4'd5, 8'b00000};
            8'h36: return {4'd5, 8'b10000};   8'h37: return {4'd5, 8'b11000};
            8'h38: return {4'd5, 8'b11100};   8'h39: return {4'd5, 8'b11110};
            8'h2E: return {4'd6, 8'b010101};  8'h2C: return {4'd6, 8'b110011};
            8'h3A: return {4'd6, 8'b111000};  8'h3F: return {4'd6, 8'b001100};
            8'h27: return {4'd6, 8'b011110};  8'h2D: return {4'd6, 8'b100001};
            8'h2F: return {4'd5, 8'b10010};   8'h28: return {4'd5, 8'b10110};
            8'h29: return {4'd6, 8'b101101};  8'h22: return {4'd6, 8'b010010};
            8'h3D: return {4'd5, 8'b10001};   8'h2B: return {4'd5, 8'b01010};
            8'h40: return {4'd6, 8'b011010};
            default: return 12'd0;
        endcase
    endfunction

    // Packs elements into 3-bit codes, first element in bits [23:21].
    function automatic logic [23:0] build_pattern(input logic [3:0] len, input logic [7:0] bits);
        logic [23:0] p;
        logic [7:0]  b;
        p = '0;
        b = bits << (4'd8 - len);
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < len) begin
                p = {p[20:0], (4'(i) == len - 4'd1), 1'b1, b[7]};
                b = b << 1;
            end else begin
                p = {p[20:0], 3'b000};
            end
        end
        return p;
    endfunction

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          s_ready_q;
    logic          push, pop, fifo_empty;
    logic [7:0]    head;

    state_t        state_q, state_d;
    logic [23:0]   pat_q, pat_d;
    logic [PW-1:0] presc_q;
    logic [UW-1:0] unit_q, dur;
    logic          key_q, tick, done, fetch;
    logic [11:0]   lk;

    assign push       = s_valid && s_ready_q;
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_mem[rd_ptr_q];
    assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign s_ready    = s_ready_q;
    assign key_out    = key_q;
    assign busy       = !(state_q == IDLE && fifo_empty);
    assign tick       = (presc_q == PW'(UNIT_CYCLES - 1));
    assign done       = tick && (unit_q == dur - UW'(1));

    // FIFO storage write (no reset needed; pointers define validity)
    always_ff @(posedge clk) begin
        if (push && !rst) fifo_mem[wr_ptr_q] <= s_data;
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            s_ready_q <= (count_d != (AW+1)'(FIFO_DEPTH));
        end
    end

    // Length of the current state in units
    always_comb begin
        dur = UW'(1);
        case (state_q)
            MARK:    dur = pat_q[21] ? UW'(3) : UW'(1);
            CGAP:    dur = UW'(3);
            WGAP:    dur = UW'(WORD_GAP_UNITS - 3);
            default: dur = UW'(1);
        endcase
    end

    // Next state; gaps that finish with data waiting fetch directly so
    // back-to-back characters get no extra idle cycle
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        pop      = 1'b0;
        err_flag = 1'b0;
        fetch    = 1'b0;
        lk       = morse_lookup(head);
        case (state_q)
            IDLE: fetch = 1'b1;
            MARK: if (done) begin
                state_d = pat_q[23] ? CGAP : EGAP;
                pat_d   = pat_q << 3;
            end
            EGAP: if (done) state_d = MARK;
            CGAP, WGAP: if (done) begin
                fetch   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (fetch && !fifo_empty) begin
            pop = 1'b1;
            if (head == 8'h20) begin
                state_d = WGAP;
            end else begin
                state_d = MARK;
                if (lk[11:8] == 4'd0) begin
                    pat_d    = build_pattern(4'd8, 8'd0);
                    err_flag = 1'b1;
                end else begin
                    pat_d = build_pattern(lk[11:8], lk[7:0]);
                end
            end
        end
    end

    // State, pattern, unit prescaler (restarted on each state entry) and key
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            presc_q <= '0;
            unit_q  <= '0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            key_q   <= (state_d == MARK);
            if (done || pop || state_q == IDLE) begin
                presc_q <= '0;
                unit_q  <= '0;
            end else if (tick) begin
                presc_q <= '0;
                unit_q  <= unit_q + UW'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_unit_morse_keyer.sv
// Directed bench for unit_morse_keyer with UNIT_CYCLES=2, FIFO_DEPTH=4,
// WORD_GAP_UNITS=7; expected run lengths are computed by hand.
module tb_unit_morse_keyer;

    logic       clk = 1'b0;
    logic       rst, s_valid, s_ready, key_out, busy, err_flag;
    logic [7:0] s_data;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    bit saw_not_ready;

    unit_morse_keyer #(
        .UNIT_CYCLES(2), .FIFO_DEPTH(4), .WORD_GAP_UNITS(7)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .key_out(key_out), .busy(busy), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    // Counts cycles with err_flag high
    always @(negedge clk) if (err_flag) err_cnt++;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    // Offers one byte and holds it until accepted
    task automatic send_byte(input logic [7:0] c);
        logic r;
        s_valid = 1'b1;
        s_data  = c;
        do begin
            r = s_ready;
            if (!r) saw_not_ready = 1'b1;
            @(posedge clk);
            #1;
        end while (!r);
        s_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Returns at the first negedge sample with key_out high (bounded)
    task automatic wait_rise(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!key_out && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq(tag, int'(key_out), 1);
    endtask

    // Measures consecutive samples at level lvl while busy and checks the count
    task automatic expect_run(input string tag, input logic lvl, input int exp);
        int n;
        n = 0;
        while (key_out == lvl && busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq(tag, n, exp);
    endtask

    int base;
    int hi;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; saw_not_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_key", int'(key_out), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_ready", int'(s_ready), 1);
        check_eq("reset_err", int'(err_flag), 0);

        // 'e': latency, one dot then character gap
        base = err_cnt;
        send_byte(8'h65);
        @(negedge clk);
        check_eq("e_lat_cycle1_key", int'(key_out), 0);
        check_eq("e_lat_cycle1_busy", int'(busy), 1);
        @(negedge clk);
        check_eq("e_lat_cycle2_key", int'(key_out), 1);
        expect_run("e_mark", 1'b1, 2);
        expect_run("e_cgap", 1'b0, 6);
        check_eq("e_idle_busy", int'(busy), 0);
        check_eq("e_err_cycles", err_cnt - base, 0);

        // 'A': dot, element gap, dash, character gap
        send_byte(8'h41);
        wait_rise("a_rise");
        expect_run("a_dot", 1'b1, 2);
        expect_run("a_egap", 1'b0, 2);
        expect_run("a_dash", 1'b1, 6);
        expect_run("a_cgap", 1'b0, 6);
        check_eq("a_idle_busy", int'(busy), 0);

        // "E E": word gap of exactly 7 units between the two dots
        fork
            send_str("E E");
            begin
                wait_rise("ee_rise");
                expect_run("ee_mark1", 1'b1, 2);
                expect_run("ee_wordgap", 1'b0, 14);
                expect_run("ee_mark2", 1'b1, 2);
                expect_run("ee_cgap", 1'b0, 6);
            end
        join
        check_eq("ee_idle_busy", int'(busy), 0);

        // 0x7E: unsupported, eight dots and a single err pulse
        base = err_cnt;
        fork
            send_byte(8'h7E);
            begin
                wait_rise("err_rise");
                for (int k = 0; k < 8; k++) begin
                    expect_run($sformatf("err_dot%0d", k), 1'b1, 2);
                    expect_run($sformatf("err_gap%0d", k), 1'b0, (k == 7) ? 6 : 2);
                end
            end
        join
        check_eq("err_idle_busy", int'(busy), 0);
        check_eq("err_pulse_cycles", err_cnt - base, 1);

        // Six 'T' with s_valid held: backpressure, nothing lost or duplicated
        saw_not_ready = 1'b0;
        fork
            send_str("TTTTTT");
            begin
                wait_rise("t6_rise");
                for (int k = 0; k < 6; k++) begin
                    expect_run($sformatf("t6_mark%0d", k), 1'b1, 6);
                    expect_run($sformatf("t6_gap%0d", k), 1'b0, 6);
                end
            end
        join
        check_eq("t6_saw_backpressure", int'(saw_not_ready), 1);
        check_eq("t6_idle_busy", int'(busy), 0);
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (key_out) hi++;
        end
        check_eq("t6_no_extra_mark", hi, 0);

        // Reset during the 3rd cycle of a 'T' mark with two more queued
        fork
            send_str("TTT");
            begin
                wait_rise("rst_rise");
                @(negedge clk);
                @(negedge clk);
                check_eq("rst_mark_cycle3", int'(key_out), 1);
                rst = 1'b1;
                @(posedge clk);
                #1;
                check_eq("rst_key", int'(key_out), 0);
                check_eq("rst_busy", int'(busy), 0);
                check_eq("rst_ready", int'(s_ready), 1);
                rst = 1'b0;
            end
        join
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (key_out || busy) hi++;
        end
        check_eq("rst_queue_discarded", hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
